// File: rtl/onehot_scan_encoder_if.sv
// Handshake bundle for onehot_scan_encoder: a vector-in stream and an index-out stream.
// The encoder takes the slave view; the producer/consumer side takes the master view.
interface onehot_scan_encoder_if #(
    parameter int N     = 4,
    parameter int IDX_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_none;

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_none
    );

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_none
    );
endinterface

// File: rtl/onehot_scan_encoder.sv
// Captures an N-bit request vector, then emits the index of each set bit, lowest first,
// one beat per output handshake. An all-zero vector yields a single out_none beat.
module onehot_scan_encoder #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    onehot_scan_encoder_if.slave   bus
);
    typedef enum logic [0:0] {IDLE, EMIT} state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     pending_reg, pending_next;
    logic             in_ready_reg, in_ready_next;
    logic             out_valid_reg, out_valid_next;
    logic [IDX_W-1:0] out_idx_reg, out_idx_next;
    logic             out_last_reg, out_last_next;
    logic             out_none_reg, out_none_next;

    logic [N-1:0]     clear_mask;
    logic [N-1:0]     remaining;

    // Scan from the top so the last assignment wins with the lowest set index.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_clear
            assign clear_mask[gi] = (out_idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign remaining = pending_reg & ~clear_mask;

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        in_ready_next  = in_ready_reg;
        out_valid_next = out_valid_reg;
        out_idx_next   = out_idx_reg;
        out_last_next  = out_last_reg;
        out_none_next  = out_none_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next     = EMIT;
                    pending_next   = bus.in_vec;
                    in_ready_next  = 1'b0;
                    out_valid_next = 1'b1;
                    if (bus.in_vec != '0) begin
                        out_idx_next  = lowest_idx(bus.in_vec);
                        out_last_next = single_bit(bus.in_vec);
                        out_none_next = 1'b0;
                    end else begin
                        out_idx_next  = '0;
                        out_last_next = 1'b1;
                        out_none_next = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_valid_reg && bus.out_ready) begin
                    pending_next = remaining;
                    if (out_last_reg) begin
                        state_next     = IDLE;
                        in_ready_next  = 1'b1;
                        out_valid_next = 1'b0;
                        out_idx_next   = '0;
                        out_last_next  = 1'b0;
                        out_none_next  = 1'b0;
                    end else begin
                        out_idx_next  = lowest_idx(remaining);
                        out_last_next = single_bit(remaining);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_last_reg  <= 1'b0;
            out_none_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
            out_idx_reg   <= out_idx_next;
            out_last_reg  <= out_last_next;
            out_none_reg  <= out_none_next;
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_idx   = out_idx_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_none  = out_none_reg;
endmodule
